// File: rtl/iir_mac_sequencer_if.sv
// iir_mac_sequencer_if
//   Sample handshake bundle between the sample source, the IIR sequencer and
//   the sample sink.
//   Signals:
//     in_valid  / in_ready  / in_data  : input sample x[n] (valid/ready)
//     out_valid / out_ready / out_data : result y[n] (valid/ready)
//   Modports:
//     master : the environment side (drives samples, accepts results)
//     slave  : the sequencer side
interface iir_mac_sequencer_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/iir_mac_sequencer.sv
// iir_mac_sequencer
//   Time-multiplexed controller for a direct-form IIR filter. One sample is
//   accepted per handshake, then a single shared multiply-accumulate walks the
//   4 feed-forward (b) and 6 feedback (a) taps, one product per clock. The
//   accumulated sum is shifted right by FRAC, narrowed to DW bits, returned on
//   the output handshake and pushed into the y history.
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset
//     a_c[0:5] : signed feedback coefficients (pre-negated), latched on accept
//     b_c[0:3] : signed feed-forward coefficients, latched on accept
//     clear    : synchronous history flush / abort of the sample in flight
//     busy     : high whenever the sequencer is not idle
//     sat_flag : sticky clipping indicator (only live with IIR_SAT_EN)
//     io       : sample in/out handshake (iir_mac_sequencer_if.slave)
//   Build option:
//     IIR_SAT_EN : when defined, results are saturated to the DW range and
//                  sat_flag records clipping; otherwise results wrap and
//                  sat_flag is tied low.
module iir_mac_sequencer #(
  parameter int DW    = 16,
  parameter int AW    = 15,
  parameter int BW    = 12,
  parameter int FRAC  = 14,
  parameter int ACC_W = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [AW-1:0] a_c [0:5],
  input  logic signed [BW-1:0] b_c [0:3],
  input  logic                 clear,
  output logic                 busy,
  output logic                 sat_flag,
  iir_mac_sequencer_if.slave   io
);

  typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

  state_t state, state_next;

  logic signed [DW-1:0]    x_h [0:3];
  logic signed [DW-1:0]    y_h [0:5];
  logic signed [AW-1:0]    a_s [0:5];
  logic signed [BW-1:0]    b_s [0:3];
  logic signed [ACC_W-1:0] acc;
  logic [3:0]              cnt;
  logic signed [DW-1:0]    out_data_r;
  logic                    out_valid_r;

  logic signed [AW-1:0]    coef;
  logic signed [DW-1:0]    samp;
  logic signed [ACC_W-1:0] coef_w;
  logic signed [ACC_W-1:0] samp_w;
  logic signed [ACC_W-1:0] prod;
  logic signed [DW-1:0]    r;

  // Ready is purely a function of the state register, so there is never a
  // combinational path from out_ready to in_ready.
  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = out_valid_r;
  assign io.out_data  = out_data_r;
  assign busy         = (state != IDLE);

  // Tap selector: counts 0..3 pair b_k with x[n-k], counts 4..9 pair
  // a_(cnt-4) with y[n-1-(cnt-4)]. b is sign-extended to the a width so the
  // multiplier sees one coefficient format.
  always_comb begin
    coef = '0;
    samp = '0;
    for (int k = 0; k < 4; k++) begin
      if (cnt == 4'(k)) begin
        coef = {{(AW-BW){b_s[k][BW-1]}}, b_s[k]};
        samp = x_h[k];
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (cnt == 4'(k + 4)) begin
        coef = a_s[k];
        samp = y_h[k];
      end
    end
  end

  // Both operands are widened to the accumulator width before multiplying so
  // the full-precision product lands sign-extended in ACC_W bits.
  assign coef_w = {{(ACC_W-AW){coef[AW-1]}}, coef};
  assign samp_w = {{(ACC_W-DW){samp[DW-1]}}, samp};
  assign prod   = coef_w * samp_w;

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic                    clip;
  logic                    sat_r;

  assign shifted = acc >>> FRAC;

  // Clamp the floored sum into the DW range; the clamped value is what gets
  // both output and fed back into the y history.
  always_comb begin
    clip = 1'b0;
    r    = shifted[DW-1:0];
    if (shifted > SAT_MAX) begin
      clip = 1'b1;
      r    = {1'b0, {(DW-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      clip = 1'b1;
      r    = {1'b1, {(DW-1){1'b0}}};
    end
  end

  // Sticky clipping flag, armed only at the rounding step and dropped by
  // reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sat_r <= 1'b0;
    end else if (state == RND && clip) begin
      sat_r <= 1'b1;
    end
  end

  assign sat_flag = sat_r;
`else
  // Plain two's-complement wrap: keep the low DW bits of the floored sum.
  assign r        = DW'(acc >>> FRAC);
  assign sat_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clear overrides every handshake and returns to IDLE.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (io.in_valid) state_next = MAC;
        MAC:     if (cnt == 4'd9) state_next = RND;
        RND:     state_next = OUT;
        OUT:     if (io.out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: history shifting, coefficient shadowing, accumulation and the
  // output register. Coefficients are captured only at accept so later
  // changes cannot disturb the sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        x_h[k] <= '0;
        b_s[k] <= '0;
      end
      for (int k = 0; k < 6; k++) begin
        y_h[k] <= '0;
        a_s[k] <= '0;
      end
      acc         <= '0;
      cnt         <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < 4; k++) x_h[k] <= '0;
      for (int k = 0; k < 6; k++) y_h[k] <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            for (int k = 3; k > 0; k--) x_h[k] <= x_h[k-1];
            x_h[0] <= io.in_data;
            for (int k = 0; k < 4; k++) b_s[k] <= b_c[k];
            for (int k = 0; k < 6; k++) a_s[k] <= a_c[k];
            acc <= '0;
            cnt <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          cnt <= cnt + 4'd1;
        end
        RND: begin
          out_data_r  <= r;
          out_valid_r <= 1'b1;
          for (int k = 5; k > 0; k--) y_h[k] <= y_h[k-1];
          y_h[0] <= r;
        end
        OUT: begin
          if (io.out_ready) out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// tb_iir_mac_sequencer
//   Directed bench for iir_mac_sequencer: pass-through, feedback decay,
//   clear/reset aborts, output backpressure, coefficient shadowing and the
//   saturation/wrap behaviour selected by IIR_SAT_EN. Expected values are
//   hand-computed from y[n] = (sum b_k*x[n-k] + sum a_k*y[n-1-k]) >>> 14.
module tb_iir_mac_sequencer;

  logic                clk;
  logic                rst;
  logic                clear;
  logic signed [14:0]  a_c [0:5];
  logic signed [11:0]  b_c [0:3];
  logic                busy;
  logic                sat_flag;
  int                  checks;
  int                  errors;

  iir_mac_sequencer_if #(.DW(16)) bus ();

  iir_mac_sequencer #(
    .DW(16), .AW(15), .BW(12), .FRAC(14), .ACC_W(36)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_c      (a_c),
    .b_c      (b_c),
    .clear    (clear),
    .busy     (busy),
    .sat_flag (sat_flag),
    .io       (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on a miss counts the error and reports.
  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Feed b0..b3 and a0; the remaining feedback taps are always zero here.
  task automatic setCoeffs(input int b0, input int b1, input int b2,
                           input int b3, input int a0);
    b_c[0] = 12'(b0);
    b_c[1] = 12'(b1);
    b_c[2] = 12'(b2);
    b_c[3] = 12'(b3);
    a_c[0] = 15'(a0);
    for (int k = 1; k < 6; k++) a_c[k] = '0;
  endtask

  // Offer one sample; returns on the falling edge just after the accept edge.
  task automatic applyStimulus(input int x);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("accept_ready", bus.in_ready, 1);
    bus.in_data  = 16'(x);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, check latency from the call point, data and
  // in_ready; complete the handshake if the sink is ready.
  task automatic waitResult(input string tag, input int exp, input int lat);
    int cyc;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_valid"}, bus.out_valid, 1);
    checkOutput({tag, "_latency"}, cyc, lat);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
    checkOutput({tag, "_data"}, $signed(bus.out_data), exp);
    if (bus.out_ready) begin
      @(negedge clk);
      checkOutput({tag, "_done"}, bus.out_valid, 0);
    end
  endtask

  task automatic clearPulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    setCoeffs(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_data", $signed(bus.out_data), 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sat_flag", sat_flag, 0);

    $display("[TB] pass-through");
    setCoeffs(1024, 0, 0, 0, 0);
    applyStimulus(16384);
    checkOutput("pass_busy", busy, 1);
    checkOutput("pass_in_ready_busy", bus.in_ready, 0);
    waitResult("pass", 1024, 11);

    $display("[TB] feedback decay");
    clearPulse();
    setCoeffs(1024, 0, 0, 0, 8192);
    applyStimulus(16384);
    waitResult("decay0", 1024, 11);
    applyStimulus(0);
    waitResult("decay1", 512, 11);
    applyStimulus(0);
    waitResult("decay2", 256, 11);

    $display("[TB] clear mid-MAC");
    applyStimulus(16384);
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_out_valid", bus.out_valid, 0);
    checkOutput("clr_in_ready", bus.in_ready, 1);
    repeat (12) @(negedge clk);
    checkOutput("clr_no_output", bus.out_valid, 0);
    applyStimulus(16384);
    waitResult("clr_fresh", 1024, 11);

    $display("[TB] reset mid-MAC");
    applyStimulus(16384);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstm_busy", busy, 0);
    checkOutput("rstm_out_valid", bus.out_valid, 0);
    checkOutput("rstm_out_data", $signed(bus.out_data), 0);
    repeat (12) @(negedge clk);
    checkOutput("rstm_no_output", bus.out_valid, 0);
    applyStimulus(16384);
    waitResult("rstm_fresh", 1024, 11);

    $display("[TB] backpressure");
    clearPulse();
    setCoeffs(1024, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    applyStimulus(16384);
    waitResult("bp", 1024, 11);
    bus.in_data  = 16'sd8192;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_data", $signed(bus.out_data), 1024);
      checkOutput("bp_hold_valid", bus.out_valid, 1);
      checkOutput("bp_hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_released", bus.out_valid, 0);
    checkOutput("bp_idle_busy", busy, 0);
    checkOutput("bp_idle_in_ready", bus.in_ready, 1);
    @(negedge clk);
    checkOutput("bp_second_accept", busy, 1);
    bus.in_valid = 1'b0;
    waitResult("bp_second", 512, 11);

    $display("[TB] coefficient shadowing");
    setCoeffs(1024, 0, 0, 0, 0);
    applyStimulus(16384);
    repeat (2) @(negedge clk);
    b_c[0] = '0;
    waitResult("shadow_inflight", 1024, 9);
    applyStimulus(16384);
    waitResult("shadow_next", 0, 11);

    $display("[TB] saturation / wrap");
    clearPulse();
    setCoeffs(2047, 2047, 2047, 2047, 16383);
    applyStimulus(32767);
    waitResult("sat0", 4093, 11);
    applyStimulus(32767);
    waitResult("sat1", 12280, 11);
    applyStimulus(32767);
    waitResult("sat2", 24560, 11);
    checkOutput("sat2_flag", sat_flag, 0);
    applyStimulus(32767);
`ifdef IIR_SAT_EN
    waitResult("sat3", 32767, 11);
    checkOutput("sat3_flag", sat_flag, 1);
`else
    waitResult("sat3", -24602, 11);
    checkOutput("sat3_flag", sat_flag, 0);
`endif
    clearPulse();
    checkOutput("sat_flag_cleared", sat_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
